// File: rtl/game_pkg.sv
// Shared constants and types for the 8x8 LED Flappy Bird game blocks.
package game_pkg;

    localparam int unsigned ROWS      = 8;
    localparam int unsigned COLS      = 8;
    localparam int unsigned BIRD_COL  = 6;
    localparam int unsigned SCORE_COL = 7;

    // Pipe-gap LFSR: all-zero start, XNOR feedback from bits 5 and 4 (x^6+x^5+1).
    localparam int unsigned LFSR_W     = 6;
    localparam logic [5:0]  LFSR_RESET = 6'b000000;
    localparam int unsigned LFSR_TAP_HI = 5;
    localparam int unsigned LFSR_TAP_LO = 4;

    // One matrix column, index = row (0 bottom, 7 top).
    typedef logic [ROWS-1:0] col_t;

endpackage

// File: rtl/lfsr6.sv
// Free-running 6-bit XNOR LFSR, period 63; all-ones lock-up state is unreachable from reset.
module lfsr6
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [5:0] q
);

    // Shift left, feeding back the XNOR of the two tap bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= LFSR_RESET;
        end else begin
            q <= {q[4:0], ~(q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO])};
        end
    end

endmodule

// File: rtl/flappy_game_monitor.sv
// Game-status monitor: pipe-gap random selector, sticky loss flag and per-pipe score pulse.
module flappy_game_monitor
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  col_t       bird_col,
    input  col_t       pipe_col,
    input  logic       ground_hit,
    input  col_t       score_col,
    output logic [3:0] rand_sel,
    output logic       loss,
    output logic       score_pulse
);

    logic [5:0] lfsr_q;
    logic       hit;
    logic       present;
    logic       score_seen;
    logic       unused_lfsr_ends;

    lfsr6 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign rand_sel         = lfsr_q[4:1];
    assign unused_lfsr_ends = lfsr_q[5] ^ lfsr_q[0];

    // Collision and pipe-presence detection from the current column contents.
    always_comb begin
        hit     = (|(bird_col & pipe_col)) | ground_hit;
        // A pipe column is recognised by both end rows being lit.
        present = score_col[ROWS-1] & score_col[0];
    end

    // Sticky loss, presence history and rising-edge score pulse; no scoring once a hit occurs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loss        <= 1'b0;
            score_seen  <= 1'b0;
            score_pulse <= 1'b0;
        end else begin
            loss        <= loss | hit;
            score_seen  <= present;
            score_pulse <= present & ~score_seen & ~loss & ~hit;
        end
    end

endmodule

// File: tb/tb_flappy_game_monitor.sv
// Directed self-checking bench for flappy_game_monitor.
module tb_flappy_game_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bird_col = 8'h00;
    logic [7:0] pipe_col = 8'h00;
    logic       ground_hit = 1'b0;
    logic [7:0] score_col = 8'h00;
    logic [3:0] rand_sel;
    logic       loss;
    logic       score_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    flappy_game_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .bird_col    (bird_col),
        .pipe_col    (pipe_col),
        .ground_hit  (ground_hit),
        .score_col   (score_col),
        .rand_sel    (rand_sel),
        .loss        (loss),
        .score_pulse (score_pulse)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    function automatic logic [5:0] lfsr_next(input logic [5:0] s);
        return {s[4:0], ~(s[5] ^ s[4])};
    endfunction

    task automatic test_reset();
        #2;
        n_checks++;
        if (rand_sel !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_rand_sel: got %b expected 0000", rand_sel);
        end
        n_checks++;
        if (loss !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_loss: got %b expected 0", loss);
        end
        n_checks++;
        if (score_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_score_pulse: got %b expected 0", score_pulse);
        end
        reset = 1'b0;
    endtask

    task automatic test_lfsr();
        logic [3:0] exp_seq [0:7];
        logic [5:0] m;
        exp_seq[0] = 4'b0000; exp_seq[1] = 4'b0000; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0011;
        exp_seq[4] = 4'b0111; exp_seq[5] = 4'b1111; exp_seq[6] = 4'b1111; exp_seq[7] = 4'b1110;
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (rand_sel !== exp_seq[0]) begin
            n_fail++;
            $display("FAIL lfsr_seq[0]: got %b expected %b", rand_sel, exp_seq[0]);
        end
        reset = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            n_checks++;
            if (rand_sel !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL lfsr_seq[%0d]: got %b expected %b", i, rand_sel, exp_seq[i]);
            end
        end
        m = 6'b111101;
        for (int c = 8; c <= 70; c++) begin
            tick();
            m = lfsr_next(m);
            n_checks++;
            if (rand_sel !== m[4:1]) begin
                n_fail++;
                $display("FAIL lfsr_run[%0d]: got %b expected %b", c, rand_sel, m[4:1]);
            end
            n_checks++;
            if (dut.u_lfsr.q === 6'b111111) begin
                n_fail++;
                $display("FAIL lfsr_lockup[%0d]: got %b expected not 111111", c, dut.u_lfsr.q);
            end
            if (c == 63) begin
                n_checks++;
                if (dut.u_lfsr.q !== 6'b000000) begin
                    n_fail++;
                    $display("FAIL lfsr_period: got %b expected 000000", dut.u_lfsr.q);
                end
            end
        end
    endtask

    task automatic test_pipe_hit();
        pulse_reset();
        bird_col = 8'h10;
        pipe_col = 8'hEF;
        tick();
        n_checks++;
        if (loss !== 1'b0) begin
            n_fail++;
            $display("FAIL pipe_gap_no_loss: got %b expected 0", loss);
        end
        pipe_col = 8'hF0;
        #2;
        n_checks++;
        if (loss !== 1'b0) begin
            n_fail++;
            $display("FAIL pipe_hit_latency: got %b expected 0", loss);
        end
        tick();
        n_checks++;
        if (loss !== 1'b1) begin
            n_fail++;
            $display("FAIL pipe_hit_loss: got %b expected 1", loss);
        end
        pipe_col = 8'h00;
        tick();
        tick();
        n_checks++;
        if (loss !== 1'b1) begin
            n_fail++;
            $display("FAIL pipe_loss_sticky: got %b expected 1", loss);
        end
        bird_col = 8'h00;
    endtask

    task automatic test_ground();
        pulse_reset();
        tick();
        n_checks++;
        if (loss !== 1'b0) begin
            n_fail++;
            $display("FAIL ground_pre: got %b expected 0", loss);
        end
        ground_hit = 1'b1;
        tick();
        ground_hit = 1'b0;
        n_checks++;
        if (loss !== 1'b1) begin
            n_fail++;
            $display("FAIL ground_loss: got %b expected 1", loss);
        end
        tick();
        n_checks++;
        if (loss !== 1'b1) begin
            n_fail++;
            $display("FAIL ground_sticky: got %b expected 1", loss);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (loss !== 1'b0) begin
            n_fail++;
            $display("FAIL ground_async_clear: got %b expected 0", loss);
        end
        reset = 1'b0;
    endtask

    task automatic test_score();
        logic exp_p [0:4];
        exp_p[0] = 1'b1; exp_p[1] = 1'b0; exp_p[2] = 1'b0; exp_p[3] = 1'b0; exp_p[4] = 1'b0;
        pulse_reset();
        tick();
        score_col = 8'hE7;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (score_pulse !== exp_p[i]) begin
                n_fail++;
                $display("FAIL score_hold[%0d]: got %b expected %b", i, score_pulse, exp_p[i]);
            end
        end
        score_col = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (score_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL score_gap[%0d]: got %b expected 0", i, score_pulse);
            end
        end
        score_col = 8'hC3;
        tick();
        n_checks++;
        if (score_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL score_second: got %b expected 1", score_pulse);
        end
        tick();
        n_checks++;
        if (score_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL score_second_width: got %b expected 0", score_pulse);
        end
        score_col = 8'h00;
        tick();
        score_col = 8'h7E;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (score_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL score_ends_unlit[%0d]: got %b expected 0", i, score_pulse);
            end
        end
        score_col = 8'h00;
    endtask

    task automatic test_score_after_loss();
        pulse_reset();
        ground_hit = 1'b1;
        tick();
        ground_hit = 1'b0;
        score_col = 8'hE7;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (score_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL score_after_loss[%0d]: got %b expected 0", i, score_pulse);
            end
        end
        score_col = 8'h00;
        pulse_reset();
        tick();
        bird_col = 8'h01;
        pipe_col = 8'h01;
        score_col = 8'hE7;
        tick();
        n_checks++;
        if (score_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL score_same_cycle_hit: got %b expected 0", score_pulse);
        end
        n_checks++;
        if (loss !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_same_cycle_hit: got %b expected 1", loss);
        end
        bird_col = 8'h00;
        pipe_col = 8'h00;
        score_col = 8'h00;
    endtask

    task automatic test_async_reset_mid_run();
        logic [3:0] exp_seq [0:7];
        exp_seq[0] = 4'b0000; exp_seq[1] = 4'b0000; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0011;
        exp_seq[4] = 4'b0111; exp_seq[5] = 4'b1111; exp_seq[6] = 4'b1111; exp_seq[7] = 4'b1110;
        pulse_reset();
        tick();
        tick();
        tick();
        score_col = 8'hE7;
        tick();
        n_checks++;
        if (score_pulse !== 1'b1 || rand_sel !== 4'b0111) begin
            n_fail++;
            $display("FAIL midrun_setup: got pulse=%b rand=%b expected pulse=1 rand=0111",
                     score_pulse, rand_sel);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (rand_sel !== 4'h0 || loss !== 1'b0 || score_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_async_reset: got rand=%b loss=%b pulse=%b expected 0000 0 0",
                     rand_sel, loss, score_pulse);
        end
        score_col = 8'h00;
        reset = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            n_checks++;
            if (rand_sel !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL midrun_restart[%0d]: got %b expected %b", i, rand_sel, exp_seq[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lfsr();
        test_pipe_hit();
        test_ground();
        test_score();
        test_score_after_loss();
        test_async_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
